// File: rtl/noc_resp_pkg.sv
// Shared definitions for the RAM-to-NoC response packetizer: flit/response codes,
// FSM state encoding, head-field bit positions and flit builders.
package noc_resp_pkg;

    localparam logic [1:0] FLIT_HEAD = 2'b10;
    localparam logic [1:0] FLIT_TAIL = 2'b11;
    localparam logic [1:0] RESP_WR   = 2'b01;
    localparam logic [1:0] RESP_RD   = 2'b10;

    localparam int HEAD_TYPE_LSB = 14;
    localparam int HEAD_RESP_LSB = 12;
    localparam int HEAD_BCNT_LSB = 10;
    localparam int HEAD_PAR_BIT  = 9;
    localparam int HEAD_DEST_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEAD,
        ST_BODY1,
        ST_BODY2,
        ST_TAIL
    } state_t;

    function automatic logic [15:0] head_flit(input logic is_read, input logic parity,
                                              input logic [7:0] dest);
        logic [15:0] f;
        f = '0;
        f[HEAD_TYPE_LSB +: 2] = FLIT_HEAD;
        f[HEAD_RESP_LSB +: 2] = is_read ? RESP_RD : RESP_WR;
        f[HEAD_BCNT_LSB +: 2] = is_read ? 2'd2 : 2'd0;
        f[HEAD_PAR_BIT]       = parity;
        f[HEAD_DEST_LSB +: 8] = dest;
        return f;
    endfunction

    function automatic logic [15:0] tail_flit(input logic [13:0] addr);
        return {FLIT_TAIL, addr};
    endfunction

endpackage

// File: rtl/resp_fifo.sv
// Synchronous power-of-two FIFO with a combinational read port that can look one
// entry past the front (i_peek) so the packetizer can start the next packet early.
module resp_fifo #(
    parameter int WIDTH = 47,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    input  logic             i_peek,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_multi
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [AW:0]      w_count;
    logic [AW-1:0]    w_rd_idx;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_count   = r_wr_ptr - r_rd_ptr;
    assign o_empty   = (w_count == '0);
    assign o_full    = (w_count == (AW+1)'(DEPTH));
    assign o_multi   = (w_count > (AW+1)'(1));
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign w_rd_idx  = i_peek ? (r_rd_ptr[AW-1:0] + 1'b1) : r_rd_ptr[AW-1:0];
    assign o_dout    = r_mem[w_rd_idx];

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are live.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end

    // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/ram_to_noc_packetizer.sv
// Buffers RAM read/write acks and serializes each into a 16-bit NoC response packet.
// Define RESP_PARITY_EN to place even parity of the read data in head bit 9.
module ram_to_noc_packetizer
    import noc_resp_pkg::*;
#(
    parameter int         RESP_DEPTH = 4,
    parameter int         ADDR_WIDTH = 14,
    parameter int         DATA_WIDTH = 32,
    parameter logic [7:0] DEST_ID    = 8'h00
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_write_ack,
    input  logic                  i_read_ack,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic [15:0]           o_flit,
    output logic                  o_flit_valid,
    input  logic                  i_flit_ready,
    output logic                  o_busy,
    output logic                  o_err
);
    typedef struct packed {
        logic                  is_read;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_flit, w_flit_nxt;
    logic        r_flit_valid, w_valid_nxt;
    logic        r_err;

    entry_t      w_push_entry, w_front;
    logic        w_ack, w_push, w_pop, w_peek, w_hs;
    logic        w_full, w_empty, w_multi, w_parity;
    logic [15:0] w_head, w_tail;

    assign w_ack        = i_read_ack | i_write_ack;
    assign w_push       = w_ack && (!w_full || w_pop);
    assign w_push_entry = '{is_read: i_read_ack, addr: i_address,
                            data: i_read_ack ? i_rdata : '0};
    // In TAIL the current packet is fully loaded, so the read port looks ahead to the next entry.
    assign w_peek       = (r_state == ST_TAIL);
    assign w_hs         = r_flit_valid && i_flit_ready;

    resp_fifo #(.WIDTH($bits(entry_t)), .DEPTH(RESP_DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_din   (w_push_entry),
        .i_pop   (w_pop),
        .i_peek  (w_peek),
        .o_dout  (w_front),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_multi (w_multi)
    );

`ifdef RESP_PARITY_EN
    assign w_parity = w_front.is_read & (^w_front.data);
`else
    assign w_parity = 1'b0;
`endif

    assign w_head = head_flit(w_front.is_read, w_parity, DEST_ID);
    assign w_tail = tail_flit(14'(w_front.addr));

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_flit_nxt  = r_flit;
        w_valid_nxt = r_flit_valid;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: if (!w_empty) begin
                w_flit_nxt  = w_head;
                w_valid_nxt = 1'b1;
                w_state_nxt = ST_HEAD;
            end
            ST_HEAD: if (w_hs) begin
                if (w_front.is_read) begin
                    w_flit_nxt  = w_front.data[31:16];
                    w_state_nxt = ST_BODY1;
                end else begin
                    w_flit_nxt  = w_tail;
                    w_state_nxt = ST_TAIL;
                end
            end
            ST_BODY1: if (w_hs) begin
                w_flit_nxt  = w_front.data[15:0];
                w_state_nxt = ST_BODY2;
            end
            ST_BODY2: if (w_hs) begin
                w_flit_nxt  = w_tail;
                w_state_nxt = ST_TAIL;
            end
            ST_TAIL: if (w_hs) begin
                w_pop = 1'b1;
                if (w_multi) begin
                    w_flit_nxt  = w_head;
                    w_state_nxt = ST_HEAD;
                end else begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_valid_nxt = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state      <= ST_IDLE;
            r_flit       <= '0;
            r_flit_valid <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_flit       <= w_flit_nxt;
            r_flit_valid <= w_valid_nxt;
            if ((i_read_ack && i_write_ack) || (w_ack && !w_push)) r_err <= 1'b1;
        end
    end

    assign o_flit       = r_flit;
    assign o_flit_valid = r_flit_valid;
    assign o_busy       = !w_empty || (r_state != ST_IDLE);
    assign o_err        = r_err;

endmodule

// File: tb/tb_ram_to_noc_packetizer.sv
// Directed self-checking bench for ram_to_noc_packetizer (DEST_ID=8'h05, RESP_DEPTH=4).
module tb_ram_to_noc_packetizer;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_write_ack;
    logic        i_read_ack;
    logic [31:0] i_rdata;
    logic [13:0] i_address;
    logic [15:0] o_flit;
    logic        o_flit_valid;
    logic        i_flit_ready;
    logic        o_busy;
    logic        o_err;

    int n_checks = 0;
    int n_errors = 0;

    // Head of a read of 32'h1234_5678: that word has odd parity, so bit 9 is set only with parity.
`ifdef RESP_PARITY_EN
    localparam logic [15:0] HEAD_RD_12345678 = 16'hAA05;
`else
    localparam logic [15:0] HEAD_RD_12345678 = 16'hA805;
`endif

    ram_to_noc_packetizer #(
        .RESP_DEPTH (4),
        .ADDR_WIDTH (14),
        .DATA_WIDTH (32),
        .DEST_ID    (8'h05)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_write_ack  (i_write_ack),
        .i_read_ack   (i_read_ack),
        .i_rdata      (i_rdata),
        .i_address    (i_address),
        .o_flit       (o_flit),
        .o_flit_valid (o_flit_valid),
        .i_flit_ready (i_flit_ready),
        .o_busy       (o_busy),
        .o_err        (o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_flit(input string tag, input logic [15:0] expected);
        check({tag, ".valid"}, {15'd0, o_flit_valid}, 16'h0001);
        check({tag, ".flit"}, o_flit, expected);
    endtask

    initial begin
        i_rst        = 1'b0;
        i_write_ack  = 1'b0;
        i_read_ack   = 1'b0;
        i_rdata      = '0;
        i_address    = '0;
        i_flit_ready = 1'b1;
        repeat (2) tick();
        i_rst = 1'b1;
        tick();
        check("reset.flit", o_flit, 16'h0000);
        check("reset.valid", {15'd0, o_flit_valid}, 16'h0000);
        check("reset.busy", {15'd0, o_busy}, 16'h0000);
        check("reset.err", {15'd0, o_err}, 16'h0000);

        // Single read, ready held high: four consecutive flits.
        i_read_ack = 1'b1; i_rdata = 32'hDEAD_BEEF; i_address = 14'h0123;
        tick();
        i_read_ack = 1'b0;
        check("rd.entry_busy", {15'd0, o_busy}, 16'h0001);
        check("rd.entry_novalid", {15'd0, o_flit_valid}, 16'h0000);
        tick(); check_flit("rd.head", 16'hA805);
        tick(); check_flit("rd.body1", 16'hDEAD);
        tick(); check_flit("rd.body2", 16'hBEEF);
        tick(); check_flit("rd.tail", 16'hC123);
        tick();
        check("rd.done_valid", {15'd0, o_flit_valid}, 16'h0000);
        check("rd.done_busy", {15'd0, o_busy}, 16'h0000);

        // Single write at the top address.
        i_write_ack = 1'b1; i_address = 14'h3FFF;
        tick();
        i_write_ack = 1'b0;
        tick(); check_flit("wr.head", 16'h9005);
        tick(); check_flit("wr.tail", 16'hFFFF);
        tick();
        check("wr.done_valid", {15'd0, o_flit_valid}, 16'h0000);
        check("wr.err", {15'd0, o_err}, 16'h0000);

        // Backpressure after body1 for five cycles.
        i_read_ack = 1'b1; i_rdata = 32'hDEAD_BEEF; i_address = 14'h0123;
        tick();
        i_read_ack = 1'b0;
        tick(); check_flit("bp.head", 16'hA805);
        tick(); check_flit("bp.body1", 16'hDEAD);
        i_flit_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(); check_flit("bp.hold", 16'hDEAD);
        end
        i_flit_ready = 1'b1;
        tick(); check_flit("bp.body2", 16'hBEEF);
        tick(); check_flit("bp.tail", 16'hC123);
        tick();
        check("bp.done_valid", {15'd0, o_flit_valid}, 16'h0000);

        // Overflow: five back-to-back writes while the router stalls.
        i_flit_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            i_write_ack = 1'b1; i_address = 14'(i);
            tick();
            if (i == 4) check("ovf.err_before", {15'd0, o_err}, 16'h0000);
        end
        i_write_ack = 1'b0;
        check("ovf.err_after", {15'd0, o_err}, 16'h0001);
        i_flit_ready = 1'b1;
        for (int p = 1; p <= 4; p++) begin
            check_flit("ovf.head", 16'h9005);
            tick();
            check_flit("ovf.tail", {2'b11, 14'(p)});
            tick();
        end
        check("ovf.done_valid", {15'd0, o_flit_valid}, 16'h0000);
        check("ovf.done_busy", {15'd0, o_busy}, 16'h0000);

        // Reset clears the sticky error.
        i_rst = 1'b0;
        tick();
        check("rst2.err", {15'd0, o_err}, 16'h0000);
        i_rst = 1'b1;
        tick();

        // Simultaneous acks: only the read is packetized, error set.
        i_read_ack = 1'b1; i_write_ack = 1'b1; i_rdata = 32'h1234_5678; i_address = 14'h0042;
        tick();
        i_read_ack = 1'b0; i_write_ack = 1'b0;
        check("both.err", {15'd0, o_err}, 16'h0001);
        tick(); check_flit("both.head", HEAD_RD_12345678);
        tick(); check_flit("both.body1", 16'h1234);
        tick(); check_flit("both.body2", 16'h5678);
        tick(); check_flit("both.tail", 16'hC042);
        tick();
        check("both.done_valid", {15'd0, o_flit_valid}, 16'h0000);
        check("both.done_busy", {15'd0, o_busy}, 16'h0000);

        // Reset mid-packet with a second entry queued: nothing may follow.
        i_read_ack = 1'b1; i_rdata = 32'hDEAD_BEEF; i_address = 14'h0123;
        tick();
        i_read_ack = 1'b0; i_write_ack = 1'b1; i_address = 14'h0007;
        tick();
        i_write_ack = 1'b0;
        check_flit("mid.head", 16'hA805);
        tick(); check_flit("mid.body1", 16'hDEAD);
        #2 i_rst = 1'b0;
        #1;
        check("mid.rst_flit", o_flit, 16'h0000);
        check("mid.rst_valid", {15'd0, o_flit_valid}, 16'h0000);
        check("mid.rst_busy", {15'd0, o_busy}, 16'h0000);
        tick();
        i_rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mid.after_valid", {15'd0, o_flit_valid}, 16'h0000);
        end
        check("mid.after_busy", {15'd0, o_busy}, 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
